// File: rtl/walksat_ctrl.sv
// WalkSAT-style local-search controller: owns the variable assignment, picks a random
// unsatisfied clause, flips one of its variables and retries until sat or out of budget.
module walksat_ctrl #(
    parameter int N     = 3,
    parameter int M     = 4,
    parameter int FLIPS = 8,
    parameter int TRIES = 4,
    localparam int FCW  = $clog2(FLIPS + 1),
    localparam int TCW  = $clog2(TRIES + 1)
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [31:0]      rand_i,
    input  logic [M-1:0]     clause_sat_i,
    input  logic [M*N-1:0]   clause_vars_i,
    output logic [N-1:0]     assign_o,
    output logic [N-1:0]     flip_mask_o,
    output logic [FCW-1:0]   flip_count_o,
    output logic [TCW-1:0]   try_count_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             found_o
);

    localparam int CW = (M > 1) ? $clog2(M) : 1;
    localparam int VW = (N > 1) ? $clog2(N) : 1;
    localparam int MW = $clog2(N + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_EVAL,
        S_SCAN_C,
        S_SCAN_V,
        S_FLIP,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    assign_q, assign_d;
    logic [N-1:0]    flip_mask_q, flip_mask_d;
    logic [FCW-1:0]  flip_count_q, flip_count_d;
    logic [TCW-1:0]  try_count_q, try_count_d;
    logic            found_q, found_d;
    logic [M-1:0]    unsat_q, unsat_d;
    logic [CW-1:0]   c_q, c_d;
    logic [VW-1:0]   v_q, v_d;
    logic [MW-1:0]   miss_q, miss_d;

    logic [N-1:0]    vars_row [M];
    logic            var_hit;
    logic [N-1:0]    one_hot_v;

    genvar gi;
    generate
        for (gi = 0; gi < M; gi++) begin : g_rows
            assign vars_row[gi] = clause_vars_i[gi*N +: N];
        end
    endgenerate

    assign var_hit   = vars_row[c_q][v_q];
    assign one_hot_v = N'(1) << v_q;

    always_comb begin
        state_d      = state_q;
        assign_d     = assign_q;
        flip_mask_d  = flip_mask_q;
        flip_count_d = flip_count_q;
        try_count_d  = try_count_q;
        found_d      = found_q;
        unsat_d      = unsat_q;
        c_d          = c_q;
        v_d          = v_q;
        miss_d       = miss_q;

        // Abort freezes assignment and counters; only the run status is dropped.
        if (abort_i) begin
            state_d = S_IDLE;
            found_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        state_d      = S_INIT;
                        found_d      = 1'b0;
                        flip_count_d = '0;
                        try_count_d  = '0;
                    end
                end
                S_INIT: begin
                    assign_d     = rand_i[N-1:0];
                    flip_mask_d  = '0;
                    flip_count_d = '0;
                    try_count_d  = try_count_q + TCW'(1);
                    state_d      = S_EVAL;
                end
                S_EVAL: begin
                    if (&clause_sat_i) begin
                        state_d = S_DONE;
                        found_d = 1'b1;
                    end else if (flip_count_q == FCW'(FLIPS) && try_count_q == TCW'(TRIES)) begin
                        state_d = S_DONE;
                        found_d = 1'b0;
                    end else if (flip_count_q == FCW'(FLIPS)) begin
                        state_d = S_INIT;
                    end else begin
                        unsat_d = ~clause_sat_i;
                        c_d     = CW'(rand_i[15:8] % M);
                        state_d = S_SCAN_C;
                    end
                end
                S_SCAN_C: begin
                    if (unsat_q[c_q]) begin
                        v_d     = VW'(rand_i[23:16] % N);
                        miss_d  = '0;
                        state_d = S_SCAN_V;
                    end else if (c_q == CW'(M - 1)) begin
                        c_d = '0;
                    end else begin
                        c_d = c_q + CW'(1);
                    end
                end
                S_SCAN_V: begin
                    if (var_hit) begin
                        state_d = S_FLIP;
                    end else if (miss_q == MW'(N - 1)) begin
                        // Every variable slot missed: an empty clause can never be satisfied.
                        state_d = S_DONE;
                        found_d = 1'b0;
                    end else begin
                        miss_d = miss_q + MW'(1);
                        v_d    = (v_q == VW'(N - 1)) ? '0 : v_q + VW'(1);
                    end
                end
                S_FLIP: begin
                    assign_d     = assign_q ^ one_hot_v;
                    flip_mask_d  = one_hot_v;
                    flip_count_d = flip_count_q + FCW'(1);
                    state_d      = S_EVAL;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q      <= S_IDLE;
            assign_q     <= '0;
            flip_mask_q  <= '0;
            flip_count_q <= '0;
            try_count_q  <= '0;
            found_q      <= 1'b0;
            unsat_q      <= '0;
            c_q          <= '0;
            v_q          <= '0;
            miss_q       <= '0;
        end else begin
            state_q      <= state_d;
            assign_q     <= assign_d;
            flip_mask_q  <= flip_mask_d;
            flip_count_q <= flip_count_d;
            try_count_q  <= try_count_d;
            found_q      <= found_d;
            unsat_q      <= unsat_d;
            c_q          <= c_d;
            v_q          <= v_d;
            miss_q       <= miss_d;
        end
    end

    assign assign_o     = assign_q;
    assign flip_mask_o  = flip_mask_q;
    assign flip_count_o = flip_count_q;
    assign try_count_o  = try_count_q;
    assign found_o      = found_q;
    assign done_o       = (state_q == S_DONE);
    assign busy_o       = (state_q != S_IDLE) && (state_q != S_DONE);

endmodule

// File: tb/tb_walksat_ctrl.sv
// Directed bench for walksat_ctrl (N=3, M=4, FLIPS=8, TRIES=4) with a tiny clause model.
module tb_walksat_ctrl;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        abort;
    logic [31:0] rnd;
    logic [3:0]  clause_sat;
    logic [11:0] clause_vars;
    logic [2:0]  assign_w;
    logic [2:0]  flip_mask;
    logic [3:0]  flip_count;
    logic [2:0]  try_count;
    logic        busy;
    logic        done;
    logic        found;

    logic        sat_follow;
    logic [3:0]  sat_const;

    int checks_cnt  = 0;
    int errors_cnt  = 0;
    int flip_events = 0;
    int toggle_bad  = 0;

    walksat_ctrl #(.N(3), .M(4), .FLIPS(8), .TRIES(4)) dut (
        .clk_i         (clk),
        .reset_ni      (reset_n),
        .start_i       (start),
        .abort_i       (abort),
        .rand_i        (rnd),
        .clause_sat_i  (clause_sat),
        .clause_vars_i (clause_vars),
        .assign_o      (assign_w),
        .flip_mask_o   (flip_mask),
        .flip_count_o  (flip_count),
        .try_count_o   (try_count),
        .busy_o        (busy),
        .done_o        (done),
        .found_o       (found)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Clause 2 tracks assign[1] in follow mode; otherwise a fixed satisfied vector.
    always_comb begin
        clause_sat = sat_const;
        if (sat_follow) clause_sat = {1'b1, assign_w[1], 2'b11};
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic tick();
        logic [3:0] prev;
        prev = flip_count;
        @(posedge clk);
        #1;
        if (flip_count == prev + 4'd1) begin
            flip_events++;
            if (assign_w[0] !== flip_count[0]) toggle_bad++;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        check_eq(tag, 32'(done), 32'd1);
    endtask

    initial begin
        reset_n     = 1'b0;
        start       = 1'b0;
        abort       = 1'b0;
        rnd         = '0;
        sat_follow  = 1'b0;
        sat_const   = 4'hF;
        clause_vars = '0;

        #2;
        check_eq("rst_assign", 32'(assign_w), 32'd0);
        check_eq("rst_busy",   32'(busy),     32'd0);
        check_eq("rst_done",   32'(done),     32'd0);
        check_eq("rst_try",    32'(try_count), 32'd0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // Forced sat: done two cycles after the start edge.
        rnd = 32'h0000_0005;
        pulse_start();
        check_eq("fs_busy", 32'(busy), 32'd1);
        tick();
        check_eq("fs_done_early", 32'(done), 32'd0);
        tick();
        check_eq("fs_done",   32'(done),       32'd1);
        check_eq("fs_found",  32'(found),      32'd1);
        check_eq("fs_assign", 32'(assign_w),   32'h5);
        check_eq("fs_flips",  32'(flip_count), 32'd0);
        check_eq("fs_tries",  32'(try_count),  32'd1);
        check_eq("fs_mask",   32'(flip_mask),  32'd0);

        // Single flip of variable 1 satisfies clause 2.
        rnd         = 32'h0;
        sat_follow  = 1'b1;
        clause_vars = 12'h080;
        pulse_start();
        wait_done("sf_done", 100);
        check_eq("sf_assign", 32'(assign_w),   32'h2);
        check_eq("sf_mask",   32'(flip_mask),  32'h2);
        check_eq("sf_flips",  32'(flip_count), 32'd1);
        check_eq("sf_found",  32'(found),      32'd1);
        check_eq("sf_tries",  32'(try_count),  32'd1);

        // Empty clause 0: unsatisfiable, no flip ever.
        sat_follow  = 1'b0;
        sat_const   = 4'hE;
        clause_vars = 12'h248;
        rnd         = 32'h0000_0006;
        flip_events = 0;
        pulse_start();
        wait_done("ec_done", 100);
        check_eq("ec_found",  32'(found),       32'd0);
        check_eq("ec_flips",  32'(flip_count),  32'd0);
        check_eq("ec_assign", 32'(assign_w),    32'h6);
        check_eq("ec_mask",   32'(flip_mask),   32'd0);
        check_eq("ec_noflip", 32'(flip_events), 32'd0);

        // Abort while scanning variables (start edge + 3 edges puts us in SCAN_V).
        pulse_start();
        tick();
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_eq("ab_busy",   32'(busy),      32'd0);
        check_eq("ab_done",   32'(done),      32'd0);
        check_eq("ab_assign", 32'(assign_w),  32'h6);
        check_eq("ab_tries",  32'(try_count), 32'd1);
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check_eq("ab_prio_busy", 32'(busy), 32'd0);

        // Exhaustion: clause 3 never satisfied, var 0 toggles every flip.
        sat_const   = 4'h7;
        clause_vars = 12'h200;
        rnd         = 32'h0;
        pulse_start();
        flip_events = 0;
        toggle_bad  = 0;
        repeat (20) tick();
        pulse_start();
        check_eq("ex_start_ignored_try",  32'(try_count), 32'd1);
        check_eq("ex_start_ignored_busy", 32'(busy),      32'd1);
        wait_done("ex_done", 2000);
        check_eq("ex_found",   32'(found),       32'd0);
        check_eq("ex_tries",   32'(try_count),   32'd4);
        check_eq("ex_flips",   32'(flip_count),  32'd8);
        check_eq("ex_nflips",  32'(flip_events), 32'd32);
        check_eq("ex_toggle",  32'(toggle_bad),  32'd0);
        check_eq("ex_assign",  32'(assign_w),    32'd0);

        // Restart from DONE.
        rnd = 32'h0000_0005;
        pulse_start();
        check_eq("rs_done",  32'(done),       32'd0);
        check_eq("rs_found", 32'(found),      32'd0);
        check_eq("rs_tries", 32'(try_count),  32'd0);
        check_eq("rs_flips", 32'(flip_count), 32'd0);
        check_eq("rs_busy",  32'(busy),       32'd1);
        tick();
        check_eq("rs_tries_init",  32'(try_count), 32'd1);
        check_eq("rs_assign_init", 32'(assign_w),  32'h5);
        abort = 1'b1;
        tick();
        abort = 1'b0;

        // Async reset in the FLIP cycle (start edge + 7 edges).
        sat_follow  = 1'b1;
        clause_vars = 12'h080;
        rnd         = 32'h0000_0005;
        pulse_start();
        repeat (7) tick();
        check_eq("ar_pre_assign", 32'(assign_w), 32'h5);
        check_eq("ar_pre_busy",   32'(busy),     32'd1);
        #3;
        reset_n = 1'b0;
        #1;
        check_eq("ar_assign", 32'(assign_w),   32'd0);
        check_eq("ar_busy",   32'(busy),       32'd0);
        check_eq("ar_tries",  32'(try_count),  32'd0);
        check_eq("ar_flips",  32'(flip_count), 32'd0);
        check_eq("ar_mask",   32'(flip_mask),  32'd0);
        check_eq("ar_done",   32'(done),       32'd0);
        check_eq("ar_found",  32'(found),      32'd0);
        tick();
        check_eq("ar_hold_assign", 32'(assign_w), 32'd0);
        reset_n = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule

// File: doc/walksat_ctrl.md
Name: walksat_ctrl

Overview:
Local-search controller for the 3SAT datapath.
- Owns the variable assignment register and drives it into the clause-evaluation array.
- Consumes the array's per-clause satisfied vector.
- Runs a WalkSAT-style loop: load a random assignment, pick a random unsatisfied clause, flip one of its variables, and re-evaluate. It restarts after FLIPS flips and gives up after TRIES tries.

Parameters:
N, 3, number of variables (1..32)
M, 4, number of clauses (>=1)
FLIPS, 8, max flips per try (>=1)
TRIES, 4, max tries per run (>=1)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-low; 0 forces reset state immediately
start  in  1  begin a run; sampled in IDLE or DONE only
abort  in  1  synchronous; return to IDLE from any state
rand  in  32  free-running random word from the LFSR stage
clause_sat  in  M  bit m=1 when clause m is satisfied by assign; combinational from assign
clause_vars  in  M*N  flattened; bit m*N+n=1 when variable n appears in clause m
assign  out  N  current assignment, feeds clause array
flip_mask  out  N  one-hot of last flipped variable, 0 if none since INIT
flip_count  out  ceil(log2(FLIPS+1))  flips in current try
try_count  out  ceil(log2(TRIES+1))  tries started this run
busy  out  1  run in progress
done  out  1  run finished, held until start, abort or reset
found  out  1  valid when done: 1 = assign satisfies all clauses

Behaviour:
- Reset (reset=0, async):
  - state=IDLE.
  - All outputs 0: assign, flip_mask, flip_count, try_count, busy, done, found.
- States: IDLE, INIT, EVAL, SCAN_C, SCAN_V, FLIP, DONE.
- busy=1 in INIT/EVAL/SCAN_C/SCAN_V/FLIP; done=1 only in DONE.
- IDLE / DONE:
  - start=1 -> INIT.
  - Clear done, found, flip_count, try_count.
  - start in any busy state is ignored.
- INIT (1 cycle):
  - assign<=rand[N-1:0]; flip_mask<=0; flip_count<=0.
  - try_count<=try_count+1.
  - Next state EVAL.
- EVAL (1 cycle): clause_sat reflects assign registered at the previous edge. Decisions in priority order:
  - &clause_sat=1 -> DONE, found=1. Satisfaction on the final flip of the final try counts as found.
  - else flip_count==FLIPS and try_count==TRIES -> DONE, found=0.
  - else flip_count==FLIPS -> INIT.
  - else latch unsat<=~clause_sat; c<=rand[15:8] mod M; -> SCAN_C.
- SCAN_C (1 clause per cycle):
  - unsat[c]=1 -> latch v<=rand[23:16] mod N; clear miss counter; -> SCAN_V.
  - else c<=c+1, wrapping M-1 -> 0.
  - Terminates within M cycles because at least one bit is set.
- SCAN_V (1 variable per cycle):
  - clause_vars[c*N+v]=1 -> FLIP.
  - else v<=v+1, wrapping N-1 -> 0; miss counter +1.
  - After N consecutive misses the clause is empty, so the formula is unsatisfiable -> DONE, found=0, with no flip.
- FLIP (1 cycle):
  - assign[v]<=~assign[v]; flip_mask<=one-hot(v).
  - flip_count<=flip_count+1.
  - -> EVAL.
- abort=1 in any state -> IDLE next edge.
  - done and found cleared.
  - assign and counters hold their values.
  - abort has priority over start.
- assign only changes in INIT and FLIP and is held in DONE/IDLE.
- clause_sat, clause_vars and rand have no handshake. The bench must hold clause_vars stable while busy.
- Latency:
  - Start sampled at edge k -> INIT at k+1 -> EVAL at k+2.
  - Earliest done=1 is after edge k+2.
  - Each flip costs EVAL + (1..M) SCAN_C + (1..N) SCAN_V + FLIP cycles.

Test Plan:
- Forced sat: N=3, M=4, clause_sat tied 4'b1111, rand[2:0]=3'b101, start pulse -> done=1 two cycles after start edge; found=1, assign=101, flip_count=0, try_count=1, flip_mask=000.
- Single flip:
  - Setup: rand=0; bench model clause_sat[2]=assign[1], all other bits 1; clause_vars for clause 2 = 3'b010.
  - Response: assign 000 -> 010; flip_mask=010; flip_count=1; found=1; try_count=1.
- Exhaustion:
  - Setup: clause_sat tied 4'b0111; clause 3 vars=3'b001; FLIPS=8, TRIES=4.
  - Response: done with found=0, try_count=4, flip_count=8; exactly 32 FLIP cycles observed; assign[0] toggles each flip.
- Empty clause: clause_sat=4'b1110, clause 0 vars=3'b000 -> done, found=0, flip_count=0, no FLIP state entered, assign unchanged from INIT.
- Abort/reset:
  - abort during SCAN_V -> next edge busy=0, done=0, assign held.
  - reset driven low mid-FLIP between edges -> all outputs 0 immediately, without waiting for clk.
- Start rules:
  - start pulses while busy -> no effect on counters.
  - start in DONE -> new run: try_count=1, flip_count=0, assign reloaded from rand.
